// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline.
// Widths, reset PC, NOP/HALT encodings and the fetch next-PC select.
package mips_pkg;

   localparam int PC_W        = 32;
   localparam int INSTR_W     = 32;
   localparam int IMEM_ADDR_W = 20;

   localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [PC_W-1:0]    RESET_PC   = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_SEQ,
      PC_REDIRECT
   } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the memory.
// The memory samples imem_addr_o and returns imem_data_i on the falling edge.
interface if_stage_if #(
   parameter int INSTR_WIDTH    = 32,
   parameter int IMEM_ADDR_BITS = 20
);
   logic [IMEM_ADDR_BITS-1:0] imem_addr_o;
   logic [INSTR_WIDTH-1:0]    imem_data_i;

   modport master (output imem_addr_o, input imem_data_i);
   modport slave  (input imem_addr_o, output imem_data_i);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Flush inserts a bubble but keeps pc4; load takes a new fetch.
module if_id_reg #(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] instr_d,
   input  logic [PC_WIDTH-1:0]    pc4_d,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    pc4,
   output logic                   valid
);
   import mips_pkg::*;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr <= INSTR_WIDTH'(NOP_INSTR);
         pc4   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= INSTR_WIDTH'(NOP_INSTR);
         valid <= 1'b0;
      end else if (load) begin
         instr <= instr_d;
         pc4   <= pc4_d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, HALT freeze and fetch counter.
// The fetched word arrives from a negedge-read memory and lands in IF/ID one edge later.
module if_stage #(
   parameter int                    PC_WIDTH       = 32,
   parameter int                    INSTR_WIDTH    = 32,
   parameter int                    IMEM_ADDR_BITS = 20,
   parameter logic [PC_WIDTH-1:0]   RESET_PC       = mips_pkg::RESET_PC,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR    = mips_pkg::HALT_INSTR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [PC_WIDTH-1:0]    target_i,
   if_stage_if.master             imem,
   output logic [PC_WIDTH-1:0]    pc_o,
   output logic [INSTR_WIDTH-1:0] if_id_instr_o,
   output logic [PC_WIDTH-1:0]    if_id_pc4_o,
   output logic                   if_id_valid_o,
   output logic                   halted_o,
   output logic [31:0]            fetch_count_o
);
   import mips_pkg::*;

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                halted;
   logic [31:0]         fetch_count;
   logic                advance;
   logic                is_halt;
   logic                load;
   logic                flush;
   pc_sel_e             pc_sel;
   logic                unused_target_lsbs;

   assign pc_plus4           = pc + PC_WIDTH'(4);
   assign advance            = en_i & ~stall_i & ~halted;
   assign is_halt            = (imem.imem_data_i == HALT_INSTR);
   assign unused_target_lsbs = ^target_i[1:0];

   // Redirect is ignored while not advancing; once halted, an enabled edge drains a bubble.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pc_sel = PC_HOLD;
      load   = 1'b0;
      flush  = 1'b0;
      if (advance) begin
         if (redirect_i) begin
            pc_sel = PC_REDIRECT;
            flush  = 1'b1;
         end else begin
            load   = 1'b1;
            pc_sel = is_halt ? PC_HOLD : PC_SEQ;
         end
      end else if (halted && en_i) begin
         flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         unique case (pc_sel)
            PC_SEQ:      pc <= pc_plus4;
            PC_REDIRECT: pc <= {target_i[PC_WIDTH-1:2], 2'b00};
            default:     pc <= pc;
         endcase
         if (load) begin
            fetch_count <= fetch_count + 32'd1;
            if (is_halt) halted <= 1'b1;
         end
      end
   end

   if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .flush   (flush),
      .instr_d (imem.imem_data_i),
      .pc4_d   (pc_plus4),
      .instr   (if_id_instr_o),
      .pc4     (if_id_pc4_o),
      .valid   (if_id_valid_o)
   );

   // Bits above the word address alias in the memory.
   assign imem.imem_addr_o = pc[IMEM_ADDR_BITS+1:2];
   assign pc_o             = pc;
   assign halted_o         = halted;
   assign fetch_count_o    = fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: negedge-read memory, behavioural fetch model
// feeding a scoreboard, plus directed checks for each feature.
module tb_if_stage;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] pc;
      logic        halted;
      logic [31:0] count;
      logic [19:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en_i, stall_i, redirect_i;
   logic [31:0] target_i;
   logic [31:0] pc_o, if_id_instr_o, if_id_pc4_o, fetch_count_o;
   logic        if_id_valid_o, halted_o;

   logic [31:0] mem [256];
   exp_t        sb [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_halted;

   always #5 clk = ~clk;

   if_stage_if bus ();

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .target_i      (target_i),
      .imem          (bus.master),
      .pc_o          (pc_o),
      .if_id_instr_o (if_id_instr_o),
      .if_id_pc4_o   (if_id_pc4_o),
      .if_id_valid_o (if_id_valid_o),
      .halted_o      (halted_o),
      .fetch_count_o (fetch_count_o)
   );

   // Instruction memory: word read on the falling edge, 256 words aliased.
   always @(negedge clk) bus.imem_data_i = mem[bus.imem_addr_o[7:0]];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive one edge: update the model, push the expectation, then pop and compare after the edge.
   task automatic cycle(input logic r, input logic en, input logic st, input logic rd,
                        input logic [31:0] tg);
      exp_t        e;
      logic [31:0] w;
      rst = r; en_i = en; stall_i = st; redirect_i = rd; target_i = tg;
      if (r) begin
         m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
         m_halted = 1'b0; m_count = '0;
      end else if (!en || st || m_halted) begin
         if (m_halted && en) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
         end
      end else if (rd) begin
         m_pc = {tg[31:2], 2'b00}; m_instr = NOP_INSTR; m_valid = 1'b0;
      end else begin
         w       = mem[m_pc[9:2]];
         m_instr = w;
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_count = m_count + 32'd1;
         if (w == HALT_INSTR) m_halted = 1'b1;
         else                 m_pc = m_pc + 32'd4;
      end
      sb.push_back('{m_instr, m_pc4, m_valid, m_pc, m_halted, m_count, m_pc[21:2]});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o, pc_o, halted_o, fetch_count_o, bus.imem_addr_o}
          !== e) begin
         $display("FAIL scoreboard @%0t: got instr=%h pc4=%h v=%b pc=%h h=%b cnt=%0d addr=%h, want instr=%h pc4=%h v=%b pc=%h h=%b cnt=%0d addr=%h",
                  $time, if_id_instr_o, if_id_pc4_o, if_id_valid_o, pc_o, halted_o, fetch_count_o,
                  bus.imem_addr_o, e.instr, e.pc4, e.valid, e.pc, e.halted, e.count, e.addr);
      end else n_pass++;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o, fetch_count_o}
          !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0})
         $display("FAIL reset_values: pc=%h instr=%h pc4=%h v=%b h=%b cnt=%0d, want all zero",
                  pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o, fetch_count_o);
      else n_pass++;
   endtask

   task automatic test_free_run();
      logic [31:0] want_i [3];
      logic [31:0] want_p [3];
      want_i = '{32'h11, 32'h22, 32'h33};
      want_p = '{32'd4, 32'd8, 32'd12};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         n_checks++;
         if (if_id_instr_o !== want_i[i] || if_id_pc4_o !== want_p[i] || if_id_valid_o !== 1'b1)
            $display("FAIL free_run[%0d]: got %h/pc4=%h/v=%b, want %h/pc4=%h/v=1",
                     i, if_id_instr_o, if_id_pc4_o, if_id_valid_o, want_i[i], want_p[i]);
         else n_pass++;
      end
      n_checks++;
      if (fetch_count_o !== 32'd3) $display("FAIL free_run_count: got %0d, want 3", fetch_count_o);
      else n_pass++;
   endtask

   task automatic test_redirect();
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0043);
      n_checks++;
      if (if_id_valid_o !== 1'b0 || pc_o !== 32'h40)
         $display("FAIL redirect_bubble: v=%b pc=%h, want v=0 pc=00000040", if_id_valid_o, pc_o);
      else n_pass++;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (if_id_instr_o !== 32'h1616_1616 || if_id_pc4_o !== 32'h44 || if_id_valid_o !== 1'b1)
         $display("FAIL redirect_target: got %h/pc4=%h/v=%b, want 16161616/pc4=00000044/v=1",
                  if_id_instr_o, if_id_pc4_o, if_id_valid_o);
      else n_pass++;
   endtask

   task automatic test_stall_redirect();
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
         n_checks++;
         if (pc_o !== 32'h4 || if_id_instr_o !== 32'h11 || if_id_valid_o !== 1'b1)
            $display("FAIL stall_hold[%0d]: pc=%h instr=%h v=%b, want pc=00000004 instr=00000011 v=1",
                     i, pc_o, if_id_instr_o, if_id_valid_o);
         else n_pass++;
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
      n_checks++;
      if (pc_o !== 32'h80 || if_id_valid_o !== 1'b0)
         $display("FAIL stall_release: pc=%h v=%b, want pc=00000080 v=0", pc_o, if_id_valid_o);
      else n_pass++;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (if_id_instr_o !== 32'h2020_2020)
         $display("FAIL stall_target: instr=%h, want 20202020", if_id_instr_o);
      else n_pass++;
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (if_id_instr_o !== 32'hFFFF_FFFF || if_id_valid_o !== 1'b1 || halted_o !== 1'b1 || pc_o !== 32'd12)
         $display("FAIL halt_fetch: instr=%h v=%b h=%b pc=%h, want ffffffff/1/1/0000000c",
                  if_id_instr_o, if_id_valid_o, halted_o, pc_o);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, i == 1, 32'h0000_0200);
         n_checks++;
         if (if_id_valid_o !== 1'b0 || pc_o !== 32'd12 || fetch_count_o !== 32'd4 || halted_o !== 1'b1)
            $display("FAIL halt_frozen[%0d]: v=%b pc=%h cnt=%0d h=%b, want 0/0000000c/4/1",
                     i, if_id_valid_o, pc_o, fetch_count_o, halted_o);
         else n_pass++;
      end
   endtask

   task automatic test_step();
      do_reset();
      for (int p = 0; p < 3; p++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         n_checks++;
         if (fetch_count_o !== 32'(p + 1) || pc_o !== 32'(4 * (p + 1)))
            $display("FAIL step[%0d]: cnt=%0d pc=%h, want cnt=%0d pc=%h",
                     p, fetch_count_o, pc_o, p + 1, 32'(4 * (p + 1)));
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
      n_checks++;
      if (pc_o !== 32'hFFFF_FFFC || bus.imem_addr_o !== 20'hFFFFF)
         $display("FAIL wrap_target: pc=%h addr=%h, want fffffffc/fffff", pc_o, bus.imem_addr_o);
      else n_pass++;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (pc_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_instr_o !== 32'hAAAA_00FF)
         $display("FAIL wrap_pc: pc=%h pc4=%h instr=%h, want 00000000/00000000/aaaa00ff",
                  pc_o, if_id_pc4_o, if_id_instr_o);
      else n_pass++;
   endtask

   task automatic test_rst_mid_stall();
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
      n_checks++;
      if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o, fetch_count_o}
          !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0})
         $display("FAIL rst_mid_stall: pc=%h instr=%h pc4=%h v=%b h=%b cnt=%0d, want all zero",
                  pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o, fetch_count_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic en, st, rd;
      logic [31:0] tg;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         en = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 5) == 0);
         rd = ($urandom_range(0, 7) == 0);
         tg = {22'h0, 8'($urandom_range(4, 255)), 2'($urandom_range(0, 3))};
         cycle(1'b0, en, st, rd, tg);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
      mem[0]   = 32'h0000_0011;
      mem[1]   = 32'h0000_0022;
      mem[2]   = 32'h0000_0033;
      mem[3]   = 32'hFFFF_FFFF;
      mem[16]  = 32'h1616_1616;
      mem[32]  = 32'h2020_2020;
      mem[255] = 32'hAAAA_00FF;

      test_reset();
      test_free_run();
      test_redirect();
      test_stall_redirect();
      test_halt();
      test_step();
      test_wrap();
      test_rst_mid_stall();
      test_back_to_back();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS processor. Holds the program counter and drives the word address of the instruction memory, which performs a negedge-clocked read. Selects the next PC from the sequential, branch and jump paths and registers the fetched instruction into the IF/ID pipeline register. Also supports the debug unit through run/step gating, a HALT detector and a fetch counter.

## Interface
- `PC_WIDTH`, 32: program counter width, byte address.
- `INSTR_WIDTH`, 32: instruction width.
- `IMEM_ADDR_BITS`, 20: instruction-memory word-address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `HALT_INSTR`, 32'hFFFF_FFFF: encoding of the HALT instruction.
- `clk`  in  1: single clock. PC and IF/ID update on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en_i`  in  1: advance enable from the debug unit. Run mode holds it at 1; step mode pulses it for one cycle.
- `stall_i`  in  1: load-use stall from the hazard unit.
- `redirect_i`  in  1: taken branch or jump resolved in ID.
- `target_i`  in  PC_WIDTH: redirect target address.
- `imem_data_i`  in  INSTR_WIDTH: instruction-memory read data.
- `imem_addr_o`  out  IMEM_ADDR_BITS: equals `pc[IMEM_ADDR_BITS+1:2]`. Combinational from the PC register.
- `pc_o`  out  PC_WIDTH: current PC, for debug readout.
- `if_id_instr_o`  out  INSTR_WIDTH: IF/ID instruction.
- `if_id_pc4_o`  out  PC_WIDTH: IF/ID copy of PC+4.
- `if_id_valid_o`  out  1: IF/ID contents are a real instruction, not a bubble.
- `halted_o`  out  1: HALT has been fetched and fetch is frozen.
- `fetch_count_o`  out  32: number of valid instructions loaded into IF/ID.

## Operation
- `advance = en_i & ~stall_i & ~halted_o`. This is evaluated every rising edge.
- Priority at each rising edge, highest first:
  - `rst`: PC=RESET_PC, IF/ID instr=0 (NOP), pc4=0, valid=0, halted=0, count=0.
  - `~advance`: PC, IF/ID and count all hold. `redirect_i` is ignored; the hazard unit keeps `redirect_i` asserted until the stall releases.
  - `redirect_i`: PC=`{target_i[PC_WIDTH-1:2],2'b00}`. IF/ID is flushed (instr=0, valid=0). pc4 holds. Count holds.
  - Otherwise: IF/ID instr=`imem_data_i`, pc4=PC+4, valid=1, count+1.
    - If `imem_data_i == HALT_INSTR`: PC holds and halted is set to 1.
    - Else: PC=PC+4.
- Once halted:
  - PC stays frozen.
  - The first `en_i`-qualified edge after halt loads a bubble into IF/ID (instr=0, valid=0) so that the HALT drains through the pipeline.
  - Only `rst` clears halted.
- Arithmetic and width rules:
  - PC+4 wraps modulo 2^PC_WIDTH; 32'hFFFF_FFFC+4 = 0.
  - Target bits [1:0] are forced to 0.
  - PC bits above IMEM_ADDR_BITS+1 are ignored by the memory, so high addresses alias.
  - `fetch_count_o` wraps modulo 2^32.

## Timing
- With PC=P latched at rising edge n, the memory returns `mem[P>>2]` at the falling edge in cycle n. IF/ID captures it at rising edge n+1. Fetch latency is 1 cycle from PC to IF/ID.
- Redirect asserted in cycle n: the target is in the PC after edge n+1. The target instruction is in IF/ID after edge n+2. This gives one bubble.
- Stall asserted for k cycles: PC and IF/ID hold k edges. No instruction is lost or duplicated.
- `imem_addr_o` changes only just after a rising edge. It is stable at the memory's falling edge.
- Reset applies on the first rising edge with `rst`=1, regardless of any in-flight redirect, stall or halt.

## Structure
- A shared `mips_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - `HALT_INSTR`.
  - `RESET_PC`.
  - Instruction and PC width constants.
- One sub-module, `if_id_reg`, owns the IF/ID pipeline register: instr, pc4 and valid, with load, flush and hold controls.
- `if_stage` itself owns the PC register, next-PC mux, halt flag and counter.

## Test plan
- Reset then free-run, memory holding 0x11,0x22,0x33 at words 0..2, `en_i`=1: IF/ID shows 0x11/pc4=4, 0x22/pc4=8, 0x33/pc4=12 on consecutive edges. Count=3.
- Redirect to 0x40 while IF holds word 1: next IF/ID is a bubble (valid=0). The following IF/ID is instr `mem[16]` with pc4=0x44.
- `stall_i` for 2 cycles with `redirect_i` also high: PC and IF/ID unchanged for 2 edges. The redirect is applied on the first unstalled edge.
- HALT (0xFFFFFFFF) at word 3:
  - IF/ID receives HALT with valid=1 and `halted_o`=1.
  - PC remains 12 indefinitely.
  - Subsequent IF/ID loads are bubbles.
  - Count stops at 4.
- Step mode: `en_i` pulsed once every 5 cycles advances exactly one instruction per pulse. PC wrap test: PC=0xFFFFFFFC goes to 0. `rst` asserted mid-stall returns all outputs to their reset values on the next edge.
